// File: rtl/arbiter_8req.sv
// Eight-requester arbiter with fixed-priority or round-robin selection and a
// per-grant hold limit that force-releases a grant and pulses timeout.
module arbiter_8req #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       mode,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state_reg, state_next;
    logic [7:0] gnt_reg, gnt_next;
    logic [2:0] gnt_id_reg, gnt_id_next;
    logic       gnt_valid_reg, gnt_valid_next;
    logic       timeout_reg, timeout_next;
    logic [7:0] hold_reg, hold_next;
    logic [2:0] last_id_reg, last_id_next;

    logic [7:0] rot_req;
    logic [2:0] fixed_id;
    logic [2:0] rr_offset;
    logic [2:0] rr_id;
    logic [2:0] win_id;
    logic [7:0] win_onehot;

    // rot_req[k] is the requester k+1 positions above the last winner
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rot
            assign rot_req[gi] = req[3'(last_id_reg + 3'(gi) + 3'd1)];
        end
        for (gi = 0; gi < 8; gi++) begin : g_onehot
            assign win_onehot[gi] = (win_id == 3'(gi));
        end
    endgenerate

    always_comb begin
        fixed_id = '0;
        for (int i = 0; i < 8; i++) begin
            if (req[i]) fixed_id = 3'(i);
        end
    end

    always_comb begin
        rr_offset = '0;
        for (int i = 7; i >= 0; i--) begin
            if (rot_req[i]) rr_offset = 3'(i);
        end
    end

    assign rr_id  = 3'(last_id_reg + rr_offset + 3'd1);
    assign win_id = mode ? rr_id : fixed_id;

    always_comb begin
        state_next     = state_reg;
        gnt_next       = gnt_reg;
        gnt_id_next    = gnt_id_reg;
        gnt_valid_next = gnt_valid_reg;
        timeout_next   = 1'b0;
        hold_next      = hold_reg;
        last_id_next   = last_id_reg;
        case (state_reg)
            IDLE: begin
                gnt_next       = '0;
                gnt_id_next    = '0;
                gnt_valid_next = 1'b0;
                hold_next      = '0;
                if (req != 8'd0) begin
                    state_next     = GRANT;
                    gnt_next       = win_onehot;
                    gnt_id_next    = win_id;
                    gnt_valid_next = 1'b1;
                    hold_next      = 8'd1;
                    last_id_next   = win_id;
                end
            end
            GRANT: begin
                if (!req[gnt_id_reg] || hold_reg == 8'(MAX_HOLD)) begin
                    // Release always passes through IDLE, so grants never abut
                    state_next     = IDLE;
                    gnt_next       = '0;
                    gnt_id_next    = '0;
                    gnt_valid_next = 1'b0;
                    hold_next      = '0;
                    timeout_next   = req[gnt_id_reg];
                end else begin
                    hold_next = hold_reg + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            gnt_reg       <= '0;
            gnt_id_reg    <= '0;
            gnt_valid_reg <= 1'b0;
            timeout_reg   <= 1'b0;
            hold_reg      <= '0;
            last_id_reg   <= 3'd7;
        end else begin
            state_reg     <= state_next;
            gnt_reg       <= gnt_next;
            gnt_id_reg    <= gnt_id_next;
            gnt_valid_reg <= gnt_valid_next;
            timeout_reg   <= timeout_next;
            hold_reg      <= hold_next;
            last_id_reg   <= last_id_next;
        end
    end

    assign gnt       = gnt_reg;
    assign gnt_id    = gnt_id_reg;
    assign gnt_valid = gnt_valid_reg;
    assign timeout   = timeout_reg;

endmodule

// File: tb/tb_arbiter_8req.sv
// Randomized and directed bench for arbiter_8req, checked every cycle against
// a cycle-level behavioural model of the arbitration rules.
module tb_arbiter_8req;

    localparam int MAXH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       mode;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // model state
    bit m_busy;
    int m_id;
    int m_hold;
    int m_last;
    bit m_to;

    arbiter_8req #(.MAX_HOLD(MAXH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .mode     (mode),
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .gnt_valid(gnt_valid),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int pick_winner(input logic [7:0] r, input logic md, input int last);
        int w;
        w = -1;
        if (md) begin
            for (int k = 1; k <= 8 && w < 0; k++)
                if (r[(last + k) % 8]) w = (last + k) % 8;
        end else begin
            for (int i = 7; i >= 0 && w < 0; i--)
                if (r[i]) w = i;
        end
        return w;
    endfunction

    task automatic model_edge(input logic rn, input logic [7:0] r, input logic md);
        int w;
        m_to = 1'b0;
        if (!rn) begin
            m_busy = 1'b0; m_id = 0; m_hold = 0; m_last = 7;
        end else if (!m_busy) begin
            w = pick_winner(r, md, m_last);
            if (w >= 0) begin
                m_busy = 1'b1; m_id = w; m_hold = 1; m_last = w;
            end
        end else if (!r[m_id]) begin
            m_busy = 1'b0; m_id = 0; m_hold = 0;
        end else if (m_hold == MAXH) begin
            m_busy = 1'b0; m_id = 0; m_hold = 0; m_to = 1'b1;
        end else begin
            m_hold++;
        end
    endtask

    task automatic step(input logic rn, input logic [7:0] r, input logic md);
        logic [7:0] exp_gnt;
        rst_n = rn; req = r; mode = md;
        @(posedge clk);
        model_edge(rn, r, md);
        #1;
        cyc++;
        exp_gnt = m_busy ? 8'(1 << m_id) : 8'd0;
        $display("cyc=%0d rst_n=%b mode=%b req=%b gnt=%b id=%0d v=%b to=%b",
                 cyc, rn, md, r, gnt, gnt_id, gnt_valid, timeout);
        check_val("gnt", 32'(gnt), 32'(exp_gnt));
        check_val("gnt_id", 32'(gnt_id), 32'(m_id));
        check_val("gnt_valid", 32'(gnt_valid), 32'(m_busy));
        check_val("timeout", 32'(timeout), 32'(m_to));
        check_val("onehot0", 32'($onehot0(gnt)), 32'd1);
        check_val("valid_eq", 32'(gnt_valid), 32'(gnt != 8'd0));
    endtask

    initial begin
        logic [7:0] r;
        logic       md;
        rst_n = 1'b0; req = '0; mode = 1'b0;
        m_busy = 0; m_id = 0; m_hold = 0; m_last = 7; m_to = 0;

        // reset then silence
        step(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 8'h00, 1'b0);

        // fixed priority, drop of the winner hands over to next highest
        step(1'b1, 8'b10101010, 1'b0);
        check_val("fixed_first", 32'(gnt_id), 32'd7);
        step(1'b1, 8'b00101010, 1'b0);
        step(1'b1, 8'b00101010, 1'b0);
        check_val("fixed_second", 32'(gnt), 32'h20);
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h00, 1'b0);

        // hold limit, fixed mode: same requester re-wins after each timeout
        for (int i = 0; i < 16; i++) step(1'b1, 8'b00000001, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h00, 1'b0);

        // hold limit, round-robin alternates 0 and 2
        for (int i = 0; i < 22; i++) step(1'b1, 8'b00000101, 1'b1);
        step(1'b1, 8'h00, 1'b1);
        step(1'b1, 8'h00, 1'b1);

        // round-robin walk, winner drops its bit after two cycles
        step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 40; i++) begin
            r = 8'hFF;
            if (m_busy && m_hold == 2) r[m_id] = 1'b0;
            step(1'b1, r, 1'b1);
        end
        step(1'b1, 8'h00, 1'b1);

        // reset during an active grant
        step(1'b1, 8'b00001000, 1'b0);
        check_val("pre_reset_id", 32'(gnt_id), 32'd3);
        step(1'b0, 8'b00001000, 1'b0);
        check_val("reset_drop", 32'({gnt, gnt_valid, timeout}), 32'd0);
        for (int i = 0; i < 8; i++) step(1'b1, 8'b01000001, 1'b1);
        step(1'b1, 8'h00, 1'b1);

        // randomized traffic with sticky requests, mode flips and rare resets
        r = 8'h00; md = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) r = 8'($urandom);
            if ($urandom_range(0, 15) == 0) md = ~md;
            step(($urandom_range(0, 63) == 0) ? 1'b0 : 1'b1, r, md);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arbiter_8req.md
ARBITER_8REQ -- requirements
Module: arbiter_8req

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16, legal range 1..255: maximum consecutive cycles one grant is held.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
REQ-004 SHALL have port req  input  8  request vector; bit i = requester i.
REQ-005 SHALL have port mode  input  1  arbitration policy: 0 = fixed priority, 1 = round-robin.
REQ-006 SHALL have port gnt  output  8  one-hot grant vector, registered.
REQ-007 SHALL have port gnt_id  output  3  binary index of granted requester, registered.
REQ-008 SHALL have port gnt_valid  output  1  high while any grant is active, registered.
REQ-009 SHALL have port timeout  output  1  one-cycle pulse when a grant is force-released by the hold limit, registered.

Function
REQ-010 SHALL implement two states, IDLE and GRANT.
REQ-011 In IDLE with req == 0, SHALL remain in IDLE with gnt = 0, gnt_id = 0, gnt_valid = 0.
REQ-012 In IDLE with req != 0, SHALL select a winner and on the next edge enter GRANT with gnt = one-hot(winner), gnt_id = winner, gnt_valid = 1: one-cycle req-to-grant latency.
REQ-013 Fixed mode (mode=0): winner = highest-index set bit of req.
REQ-014 Round-robin mode (mode=1): winner = first set bit searching upward from (last_id+1) mod 8, wrapping 7->0.
REQ-015 last_id SHALL be an internal 3-bit register, loaded with the winner on every grant issue, in both modes.
REQ-016 mode SHALL be sampled only in IDLE; a mode change during GRANT takes effect at the next arbitration.
REQ-017 In GRANT, a 8-bit hold counter SHALL start at 1 on the first grant cycle and increment each cycle held.
REQ-018 In GRANT, if req[gnt_id] == 0, SHALL on the next edge return to IDLE with gnt = 0, gnt_valid = 0, gnt_id = 0, timeout = 0.
REQ-019 In GRANT, if req[gnt_id] == 1 and hold counter == MAX_HOLD, SHALL on the next edge return to IDLE with gnt = 0, gnt_valid = 0, gnt_id = 0, and timeout = 1 for exactly that one IDLE cycle.
REQ-020 gnt_valid SHALL therefore be high for at most MAX_HOLD consecutive cycles per grant.
REQ-021 At least one IDLE cycle (gnt = 0) SHALL separate any two grants, including back-to-back grants to the same requester.
REQ-022 Changes to req bits other than req[gnt_id] during GRANT SHALL NOT affect gnt, gnt_id or the hold counter.
REQ-023 In fixed mode after timeout, the same requester MAY win again if it is still the highest-index request; no starvation protection is required in fixed mode.
REQ-024 At all times gnt SHALL be either 0 or exactly one-hot, gnt_valid == (gnt != 0), and gnt == one-hot(gnt_id) when gnt_valid = 1.

Reset
REQ-025 When rst_n = 0 at a rising edge, SHALL set state = IDLE, gnt = 0, gnt_id = 0, gnt_valid = 0, timeout = 0, hold counter = 0, last_id = 7.
REQ-026 Reset asserted during GRANT SHALL drop the grant at that edge, with no timeout pulse.
REQ-027 The first arbitration after reset SHALL use rules REQ-013/REQ-014 with last_id = 7, so round-robin search starts at bit 0.

Verification
REQ-028 Scenario: reset, then req = 8'b00000000 for 10 cycles -> gnt = 0, gnt_valid = 0, timeout = 0 throughout.
REQ-029 Scenario: mode = 0, req = 8'b10101010 -> next cycle gnt = 8'b10000000, gnt_id = 7; then req = 8'b00101010 -> next edge gnt = 0; following edge gnt = 8'b00100000, gnt_id = 5.
REQ-030 Scenario: MAX_HOLD = 4, mode = 0, req = 8'b00000001 held -> gnt_valid high 4 cycles, then 1 cycle with gnt = 0 and timeout = 1, then gnt_id = 0 re-granted; repeats.
REQ-031 Scenario: MAX_HOLD = 4, mode = 1, req = 8'b00000101 held -> grant sequence gnt_id 0, 2, 0, 2, each 4 cycles long, each followed by 1 timeout cycle.
REQ-032 Scenario: mode = 1, req = 8'b11111111, granted requester drops its bit after 2 cycles and re-raises it -> gnt_id sequence 0, 1, 2, ..., 7, 0.
REQ-033 Scenario: rst_n = 0 for 1 cycle while gnt_id = 3 is active -> next edge all outputs 0; then mode = 1, req = 8'b01000001 -> gnt_id = 0 first, then 6 after release.
